// File: rtl/full_event_dispatcher_pkg.sv
// rtl/full_event_dispatcher_pkg.sv - shared types and default constants for the full event dispatcher
package full_event_dispatcher_pkg;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } edge_state_t;

    localparam int LS_CAPACITY     = 7500;
    // Watchdog must outlast one complete load/store cycle (fill plus drain) with margin.
    localparam int DEF_GAP_MAX     = 2 * LS_CAPACITY + 1000;
    localparam int DEF_PEND_DEPTH  = 4;
    localparam int DEF_SEQ_BITS    = 8;
    localparam int DEF_GBITS       = 14;

endpackage

// File: rtl/full_event_dispatcher_gap_watchdog.sv
// rtl/full_event_dispatcher_gap_watchdog.sv - saturating gap counter with sticky stall flag
module gap_watchdog #(
    parameter int GAP_MAX = 16000,
    parameter int GBITS   = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_edge,
    input  logic             i_clr,
    output logic [GBITS-1:0] o_gap_cnt,
    output logic             o_stall
);

    localparam logic [GBITS-1:0] GAP_C  = GBITS'(GAP_MAX);
    localparam logic [GBITS-1:0] GAP_M1 = GBITS'(GAP_MAX - 1);

    logic [GBITS-1:0] r_gap;
    logic             r_stall;
    logic             w_expire;

    // An edge arriving on the expiry cycle takes priority, so no stall is raised.
    assign w_expire = !i_edge && (r_gap == GAP_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap   <= '0;
            r_stall <= 1'b0;
        end else begin
            if (i_edge)
                r_gap <= '0;
            else if (r_gap != GAP_C)
                r_gap <= r_gap + 1'b1;
            r_stall <= w_expire | (r_stall & ~i_clr);
        end
    end

    assign o_gap_cnt = r_gap;
    assign o_stall   = r_stall;

endmodule

// File: rtl/full_event_dispatcher.sv
// rtl/full_event_dispatcher.sv - turns volume-full rising edges into sequenced, buffered events
module full_event_dispatcher
    import full_event_dispatcher_pkg::*;
#(
    parameter int PEND_DEPTH = DEF_PEND_DEPTH,
    parameter int SEQ_BITS   = DEF_SEQ_BITS,
    parameter int GAP_MAX    = DEF_GAP_MAX,
    parameter int GBITS      = DEF_GBITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                full_in,
    input  logic                clr_flags,
    input  logic                evt_ready,
    output logic                evt_valid,
    output logic [SEQ_BITS-1:0] evt_seq,
    output logic [3:0]          pend_cnt,
    output logic                overflow,
    output logic                stall,
    output logic [GBITS-1:0]    gap_cnt
);

    localparam logic [3:0] DEPTH_C = 4'(PEND_DEPTH);

    edge_state_t         r_state;
    edge_state_t         w_state_nxt;
    logic                w_edge;
    logic                w_accept;
    logic                w_drop;
    logic [3:0]          r_pend;
    logic [SEQ_BITS-1:0] r_seq;
    logic                r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= LOW;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_edge      = 1'b0;
        case (r_state)
            LOW: begin
                if (full_in) begin
                    w_state_nxt = HIGH;
                    w_edge      = 1'b1;
                end
            end
            HIGH: begin
                if (!full_in)
                    w_state_nxt = LOW;
            end
            default: w_state_nxt = LOW;
        endcase
    end

    assign evt_valid = (r_pend != 4'd0);
    assign w_accept  = evt_valid & evt_ready;
    // A same-cycle accept frees a slot, so a full buffer only drops when nothing leaves.
    assign w_drop    = w_edge & (r_pend == DEPTH_C) & ~w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 4'd0;
            r_seq  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_edge && !w_drop && !w_accept)
                r_pend <= r_pend + 4'd1;
            else if (w_accept && !w_edge)
                r_pend <= r_pend - 4'd1;
            if (w_accept)
                r_seq <= r_seq + 1'b1;
            r_ovf <= w_drop | (r_ovf & ~clr_flags);
        end
    end

    gap_watchdog #(
        .GAP_MAX (GAP_MAX),
        .GBITS   (GBITS)
    ) u_gap_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_edge    (w_edge),
        .i_clr     (clr_flags),
        .o_gap_cnt (gap_cnt),
        .o_stall   (stall)
    );

    assign evt_seq  = r_seq;
    assign pend_cnt = r_pend;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_full_event_dispatcher.sv
// tb/tb_full_event_dispatcher.sv - scoreboard bench for full_event_dispatcher
module tb_full_event_dispatcher;

    localparam int PEND_DEPTH = 4;
    localparam int SEQ_BITS   = 8;
    localparam int GAP_MAX    = 20;
    localparam int GBITS      = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                full_in = 1'b0;
    logic                clr_flags = 1'b0;
    logic                evt_ready = 1'b0;
    logic                evt_valid;
    logic [SEQ_BITS-1:0] evt_seq;
    logic [3:0]          pend_cnt;
    logic                overflow;
    logic                stall;
    logic [GBITS-1:0]    gap_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;

    int unsigned sb_q[$];
    int          m_pend = 0;
    int unsigned m_next = 0;
    logic        m_prev = 1'b0;

    full_event_dispatcher #(
        .PEND_DEPTH (PEND_DEPTH),
        .SEQ_BITS   (SEQ_BITS),
        .GAP_MAX    (GAP_MAX),
        .GBITS      (GBITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .full_in   (full_in),
        .clr_flags (clr_flags),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_seq   (evt_seq),
        .pend_cnt  (pend_cnt),
        .overflow  (overflow),
        .stall     (stall),
        .gap_cnt   (gap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model evaluated at the falling edge, on the inputs the next posedge will sample.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            m_pend = 0;
            m_next = 0;
            m_prev = 1'b0;
        end else begin
            automatic logic edge_m = full_in & ~m_prev;
            automatic logic acc_m  = (m_pend != 0) & evt_ready;
            if (acc_m) begin
                n_acc++;
                if (sb_q.size() == 0)
                    check("sb_underflow", 1, 0);
                else
                    check("sb_seq", int'(evt_seq), int'(sb_q.pop_front() % (1 << SEQ_BITS)));
            end
            if (edge_m && (m_pend < PEND_DEPTH || acc_m)) begin
                sb_q.push_back(m_next);
                m_next++;
                if (!acc_m) m_pend++;
            end else if (acc_m) begin
                m_pend--;
            end
            m_prev = full_in;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        full_in = 1'b0; clr_flags = 1'b0; evt_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse();
        full_in = 1'b1;
        tick(1);
        full_in = 1'b0;
        tick(1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, int'(evt_valid), 0);
        check({tag, "_seq"},   int'(evt_seq),   0);
        check({tag, "_pend"},  int'(pend_cnt),  0);
        check({tag, "_ovf"},   int'(overflow),  0);
        check({tag, "_stall"}, int'(stall),     0);
        check({tag, "_gap"},   int'(gap_cnt),   0);
    endtask

    initial begin
        int acc0;
        #2;
        check_zero("reset");
        do_reset();

        // Single pulse with consumer ready
        evt_ready = 1'b1;
        tick(4);
        full_in = 1'b1;
        tick(1);
        full_in = 1'b0;
        check("single_valid", int'(evt_valid), 1);
        check("single_seq0", int'(evt_seq), 0);
        tick(1);
        check("single_valid_after", int'(evt_valid), 0);
        check("single_seq1", int'(evt_seq), 1);

        // Held high then re-rise: exactly two events
        do_reset();
        evt_ready = 1'b1;
        acc0 = n_acc;
        full_in = 1'b1;
        tick(10);
        full_in = 1'b0;
        tick(2);
        full_in = 1'b1;
        tick(1);
        full_in = 1'b0;
        tick(3);
        check("held_events", n_acc - acc0, 2);
        check("held_seq", int'(evt_seq), 2);

        // Backpressure and overflow
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            pulse();
            if (i == 4) begin
                check("bp_pend4", int'(pend_cnt), 4);
                check("bp_no_ovf", int'(overflow), 0);
            end
            if (i == 5) begin
                check("bp_pend_full", int'(pend_cnt), 4);
                check("bp_ovf", int'(overflow), 1);
            end
        end
        evt_ready = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            check("drain_valid", int'(evt_valid), 1);
            tick(1);
            check("drain_pend", int'(pend_cnt), k);
        end
        check("drain_seq", int'(evt_seq), 4);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("ovf_clr", int'(overflow), 0);

        // Edge and accept together while full
        do_reset();
        repeat (4) pulse();
        check("sim_pend_pre", int'(pend_cnt), 4);
        full_in = 1'b1;
        evt_ready = 1'b1;
        tick(1);
        full_in = 1'b0;
        check("sim_pend", int'(pend_cnt), 4);
        check("sim_ovf", int'(overflow), 0);
        check("sim_seq", int'(evt_seq), 1);
        tick(5);
        check("sim_drained", int'(pend_cnt), 0);

        // Watchdog expiry, saturation, sticky stall and clear
        do_reset();
        evt_ready = 1'b1;
        tick(19);
        check("wd_gap19", int'(gap_cnt), 19);
        check("wd_nostall19", int'(stall), 0);
        tick(1);
        check("wd_gap20", int'(gap_cnt), GAP_MAX);
        check("wd_stall", int'(stall), 1);
        tick(1);
        check("wd_sat", int'(gap_cnt), GAP_MAX);
        full_in = 1'b1;
        tick(1);
        full_in = 1'b0;
        check("wd_gap_edge", int'(gap_cnt), 0);
        check("wd_stall_sticky", int'(stall), 1);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("wd_stall_clr", int'(stall), 0);

        // Edge exactly on the expiry cycle suppresses stall
        do_reset();
        evt_ready = 1'b1;
        tick(19);
        full_in = 1'b1;
        tick(1);
        full_in = 1'b0;
        check("wd_race_gap", int'(gap_cnt), 0);
        check("wd_race_stall", int'(stall), 0);
        tick(2);

        // Asynchronous reset mid-stream
        do_reset();
        repeat (3) pulse();
        check("ar_pend3", int'(pend_cnt), 3);
        #2 rst = 1'b1;
        #1;
        check_zero("async");
        tick(1);
        rst = 1'b0;
        evt_ready = 1'b1;
        full_in = 1'b1;
        tick(1);
        full_in = 1'b0;
        check("ar_first_seq", int'(evt_seq), 0);
        check("ar_first_valid", int'(evt_valid), 1);
        tick(2);
        check("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/full_event_dispatcher.md
Name: full_event_dispatcher

Overview:
- Sits directly downstream of the load/store volume controller and consumes its 1-bit "volume full" indicator.
- Converts each rising edge of that indicator into one event, buffers up to PEND_DEPTH pending events, and hands them to a consumer over a valid/ready handshake with a wrapping sequence number.
- Runs a liveness watchdog that flags a stall when no full event arrives within GAP_MAX cycles.

Parameters:
- PEND_DEPTH, 4: maximum number of undelivered events held (1..15).
- SEQ_BITS, 8: width of the event sequence number.
- GAP_MAX, 16000: cycles without a full edge before stall is flagged. Default exceeds one full load/store cycle of 2*7500.
- GBITS, 14: width of the gap counter. Must satisfy 2^GBITS > GAP_MAX.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- full_in  input  1  full indicator from the upstream load/store stage (level).
- clr_flags  input  1  synchronous clear of the sticky flags.
- evt_ready  input  1  consumer ready.
- evt_valid  output  1  an event is pending.
- evt_seq  output  SEQ_BITS  sequence number of the head event.
- pend_cnt  output  4  number of pending events.
- overflow  output  1  sticky: an edge was dropped.
- stall  output  1  sticky: watchdog expired.
- gap_cnt  output  GBITS  cycles since the last edge or reset, saturating.

Behaviour:
- Reset, asynchronous: full_q=0, pend_cnt=0, evt_valid=0, evt_seq=0, overflow=0, stall=0, gap_cnt=0, FSM=LOW. Pending events are discarded.
- Edge FSM, two states:
  - LOW: full_in=1 -> go to HIGH and raise edge for that cycle.
  - HIGH: full_in=0 -> go to LOW.
  - A held-high full_in produces exactly one edge.
  - Coming out of reset with full_in=1 counts as an edge.
- Latency: an edge sampled at posedge t makes pend_cnt increment and evt_valid=1 visible after posedge t.
- Handshake: an event is accepted in any cycle with evt_valid & evt_ready.
  - evt_valid = (pend_cnt != 0), driven from registered state with no combinational path from evt_ready.
  - While evt_valid & !evt_ready, evt_seq and evt_valid hold stable.
- Pending counter, per cycle:
  - edge only: +1.
  - accept only: -1.
  - edge and accept together: unchanged.
  - edge while pend_cnt==PEND_DEPTH with no accept: edge dropped, pend_cnt stays, overflow set.
  - edge while full with an accept in the same cycle: not dropped.
- Sequence: evt_seq increments by 1 on each accept and wraps from 2^SEQ_BITS-1 to 0. Dropped edges never consume a number.
- Watchdog, gap counter:
  - An edge sets gap_cnt to 0. Otherwise gap_cnt increments, saturating at GAP_MAX.
  - The counter runs from reset, so the first full edge must also arrive within GAP_MAX.
  - stall is set on the cycle gap_cnt transitions to GAP_MAX.
  - An edge on that same cycle wins: gap_cnt goes to 0 and stall is not set.
- Sticky flags: clr_flags=1 clears overflow and stall at the next posedge. If a set condition occurs in the same cycle, the flag ends up set.
- Mid-operation reset: all outputs return to reset values asynchronously, without waiting for clk. After reset deasserts, the first edge is evt_seq=0.
- Safety invariants for formal:
  - pend_cnt <= PEND_DEPTH.
  - evt_valid == (pend_cnt != 0).
  - gap_cnt <= GAP_MAX.
  - Once set, stall stays set until clr_flags or rst.
- Liveness property: with rst held low and evt_ready eventually always high, evt_valid implies eventually an accept.

Decomposition:
- Shared package:
  - Edge-FSM state typedef with values LOW and HIGH.
  - Default constants for PEND_DEPTH, SEQ_BITS and GAP_MAX.
  - The load/store capacity constant 7500, from which GAP_MAX is derived.
- One sub-module, gap_watchdog: the saturating gap counter plus the stall sticky flag.
  - Inputs: clk, rst, edge, clr.
  - Outputs: gap_cnt, stall.
- The top level contains the edge FSM, the pending counter, the sequence counter and the overflow flag.

Test Plan (GAP_MAX=20, PEND_DEPTH=4 unless stated):
- Single pulse: full_in high 1 cycle at cycle 5 with evt_ready=1.
  - Expect evt_valid=1 on cycle 6 with evt_seq=0, accepted there; evt_valid=0 on cycle 7 and evt_seq=1.
- Held high: full_in high for 10 cycles, then low 2 cycles, then high again.
  - Expect exactly 2 events, seq 0 and seq 1.
- Backpressure/overflow: evt_ready=0 and 6 separate pulses.
  - Expect pend_cnt=4 and overflow=1 after the 5th pulse.
  - Then evt_ready=1: events seq 0..3 delivered on consecutive cycles, pend_cnt back to 0.
- Simultaneous: pend_cnt=4, then an edge and an accept in the same cycle.
  - Expect pend_cnt stays 4 and overflow stays 0.
- Watchdog: no pulses after reset.
  - Expect gap_cnt=20 and stall=1 at cycle 20.
  - A pulse then drives gap_cnt to 0 while stall remains 1; clr_flags clears it.
  - Separately, a pulse on cycle 20 exactly leaves stall=0.
- Async reset mid-stream: assert rst between clock edges with pend_cnt=3.
  - Expect all outputs 0 before the next posedge.
  - After release, the next pulse yields evt_seq=0.
